frame_packetizer: RTL

Downstream stage of the frame counter in the sensor algorithm Qsys system. Consumes the 32-bit Avalon-ST sensor data stream (the same stream whose end-of-packet drives the frame counter) together with the live `frame_Num` count. Wraps each sensor packet as: a header word carrying a sync marker and the frame number, the unmodified payload words, and a trailer word carrying the payload word count and an error flag. Drops stray beats and counts them.

---
 rtl/frame_packetizer_pkg.sv | 52 +++++
 rtl/frame_out_reg.sv | 36 +++
 rtl/frame_packetizer.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/frame_packetizer_pkg.sv
// frame_pkg: state encoding and word layouts shared by frame_packetizer and the frame counter.
// The CHECKSUM state exists only when FRAME_PACKETIZER_CHECKSUM_EN is defined.
package frame_pkg;

    localparam int FRAME_W = 27;
    localparam logic [4:0] SYNC_DEFAULT = 5'h15;
    localparam logic [3:0] TRL_MARK = 4'hE;

    localparam int HDR_FRAME_LSB = 0;
    localparam int HDR_SYNC_LSB = 27;
    localparam int TRL_CNT_LSB = 0;
    localparam int TRL_CNT_W = 16;
    localparam int TRL_ERR_BIT = 27;
    localparam int TRL_MARK_LSB = 28;

`ifdef FRAME_PACKETIZER_CHECKSUM_EN
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEADER,
        ST_PAYLOAD,
        ST_TRAILER,
        ST_CHECKSUM
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HEADER,
        ST_PAYLOAD,
        ST_TRAILER
    } state_t;
`endif

    function automatic logic [31:0] header_word(input logic [4:0] sync,
                                                input logic [FRAME_W-1:0] frame);
        logic [31:0] w;
        w = '0;
        w[HDR_SYNC_LSB +: 5] = sync;
        w[HDR_FRAME_LSB +: FRAME_W] = frame;
        return w;
    endfunction

    function automatic logic [31:0] trailer_word(input logic err,
                                                 input logic [TRL_CNT_W-1:0] cnt);
        logic [31:0] w;
        w = '0;
        w[TRL_MARK_LSB +: 4] = TRL_MARK;
        w[TRL_ERR_BIT] = err;
        w[TRL_CNT_LSB +: TRL_CNT_W] = cnt;
        return w;
    endfunction

endpackage

// File: rtl/frame_out_reg.sv
// frame_out_reg: single-beat Avalon-ST source register; accepts a load only while free,
// holds data/sop/eop stable while the sink stalls.
module frame_out_reg (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] load_data,
    input  logic        load_sop,
    input  logic        load_eop,
    input  logic        ready,
    output logic [31:0] data,
    output logic        valid,
    output logic        sop,
    output logic        eop,
    output logic        free
);

    assign free = ~valid | ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data  <= '0;
            valid <= 1'b0;
            sop   <= 1'b0;
            eop   <= 1'b0;
        end else if (free) begin
            valid <= load;
            if (load) begin
                data <= load_data;
                sop  <= load_sop;
                eop  <= load_eop;
            end
        end
    end

endmodule

// File: rtl/frame_packetizer.sv
// frame_packetizer: wraps each sensor packet in a header (sync + frame number) and a trailer
// (word count + error flag); strays outside a packet are dropped and counted.
// Build option: FRAME_PACKETIZER_CHECKSUM_EN appends an XOR checksum beat after the trailer.
module frame_packetizer
    import frame_pkg::*;
#(
    parameter int         CNT_W = 16,
    parameter logic [4:0] SYNC  = SYNC_DEFAULT
) (
    input  logic               clk_clk,
    input  logic               rst_reset,
    input  logic [FRAME_W-1:0] frame_Num,
    input  logic [31:0]        in_data,
    input  logic               in_valid,
    input  logic               in_sop,
    input  logic               in_eop,
    output logic               in_ready,
    output logic [31:0]        out_data,
    output logic               out_valid,
    output logic               out_sop,
    output logic               out_eop,
    input  logic               out_ready,
    output logic [15:0]        drop_count,
    output logic               busy
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t             state;
    state_t             state_nxt;
    logic [FRAME_W-1:0] hdr_frame;
    logic [CNT_W-1:0]   word_cnt;
    logic [CNT_W-1:0]   word_cnt_inc;
    logic               err;
    logic               free;
    logic               accept;
    logic               abort;
    logic               load;
    logic [31:0]        load_data;
    logic               load_sop;
    logic               load_eop;
`ifdef FRAME_PACKETIZER_CHECKSUM_EN
    logic [31:0]        csum;
`endif

    function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    function automatic logic [15:0] sat_inc_drop(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign accept       = in_valid & in_ready;
    // An SOP arriving after payload has started means the previous packet lost its EOP.
    assign abort        = (state == ST_PAYLOAD) & in_valid & in_sop & (word_cnt != '0);
    assign word_cnt_inc = sat_inc_cnt(word_cnt);
    assign busy         = (state != ST_IDLE);

    always_ff @(posedge clk_clk or posedge rst_reset) begin
        if (rst_reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (in_valid & in_sop) state_nxt = ST_HEADER;
            end
            ST_HEADER: begin
                if (free) state_nxt = ST_PAYLOAD;
            end
            ST_PAYLOAD: begin
                if (abort) begin
                    state_nxt = ST_TRAILER;
                end else if (accept & in_eop) begin
                    state_nxt = ST_TRAILER;
                end
            end
            ST_TRAILER: begin
`ifdef FRAME_PACKETIZER_CHECKSUM_EN
                if (free) state_nxt = ST_CHECKSUM;
`else
                if (free) state_nxt = ST_IDLE;
`endif
            end
`ifdef FRAME_PACKETIZER_CHECKSUM_EN
            ST_CHECKSUM: begin
                if (free) state_nxt = ST_IDLE;
            end
`endif
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        load      = 1'b0;
        load_data = '0;
        load_sop  = 1'b0;
        load_eop  = 1'b0;
        case (state)
            ST_IDLE: begin
                // The SOP beat is left pending so PAYLOAD can accept it as word one.
                in_ready = ~in_sop & ~rst_reset;
            end
            ST_HEADER: begin
                load      = free;
                load_data = header_word(SYNC, hdr_frame);
                load_sop  = 1'b1;
            end
            ST_PAYLOAD: begin
                in_ready  = free & ~(in_sop & (word_cnt != '0));
                load      = accept;
                load_data = in_data;
            end
            ST_TRAILER: begin
                load      = free;
                load_data = trailer_word(err, TRL_CNT_W'(word_cnt));
`ifdef FRAME_PACKETIZER_CHECKSUM_EN
                load_eop  = 1'b0;
`else
                load_eop  = 1'b1;
`endif
            end
`ifdef FRAME_PACKETIZER_CHECKSUM_EN
            ST_CHECKSUM: begin
                load      = free;
                load_data = csum;
                load_eop  = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk_clk or posedge rst_reset) begin
        if (rst_reset) begin
            hdr_frame  <= '0;
            word_cnt   <= '0;
            err        <= 1'b0;
            drop_count <= '0;
        end else begin
            if ((state == ST_IDLE) && in_valid && in_sop) begin
                hdr_frame <= frame_Num;
            end
            if ((state == ST_IDLE) && accept) begin
                drop_count <= sat_inc_drop(drop_count);
            end
            if ((state == ST_HEADER) && free) begin
                word_cnt <= '0;
                err      <= 1'b0;
            end
            if (state == ST_PAYLOAD) begin
                if (abort) begin
                    err <= 1'b1;
                end else if (accept) begin
                    word_cnt <= word_cnt_inc;
                    if (word_cnt_inc == CNT_MAX) err <= 1'b1;
                end
            end
        end
    end

`ifdef FRAME_PACKETIZER_CHECKSUM_EN
    always_ff @(posedge clk_clk or posedge rst_reset) begin
        if (rst_reset) begin
            csum <= '0;
        end else if ((state == ST_HEADER) && free) begin
            csum <= '0;
        end else if ((state == ST_PAYLOAD) && accept) begin
            csum <= csum ^ in_data;
        end
    end
`endif

    frame_out_reg u_out_reg (
        .clk       (clk_clk),
        .rst       (rst_reset),
        .load      (load),
        .load_data (load_data),
        .load_sop  (load_sop),
        .load_eop  (load_eop),
        .ready     (out_ready),
        .data      (out_data),
        .valid     (out_valid),
        .sop       (out_sop),
        .eop       (out_eop),
        .free      (free)
    );

endmodule
